ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Control sequencer driving the register-transfer strobes of the `DataPath` block (register in/out enables, Y/Z latches, immediate buses). It accepts one 32-bit instruction word per handshake and walks it through T-states, raising exactly the strobes each step requires. It replaces hand-driven strobe sequences and produces the same one-strobe-set-per-cycle pattern the datapath expects.

## Interface

- `DATA_W`, 32, datapath word width; the immediate is sign-extended to this width.
- `NREG`, 16, number of general registers; register fields are 4 bits, and any index >= `NREG` is illegal.

- `clock` in 1: single clock; all state changes on the rising edge.
- `clear` in 1: reset, synchronous and active-high.
- `instr` in 32: instruction word. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- `instr_valid` in 1: `instr` is presented.
- `instr_ready` out 1: sequencer is idle and able to accept.
- `Rin` out NREG: one-hot register load enables.
- `Rout` out NREG: one-hot register bus drive enables.
- `Yin`, `Zin`, `Zout` out 1 each: Y latch load, Z latch load, Z drive.
- `imm_out` out DATA_W: sign-extended C onto the bus (ldi). It is 0 when unused.
- `alu_imm` out DATA_W: sign-extended C to the ALU second operand (addi). It is 0 when unused.
- `done` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: one-cycle pulse, concurrent with `done`, for an unknown opcode or an out-of-range register index.
- `step` in 1: present only under `CTRL_SEQ_STEP_EN`; advances one T-state.

## Operation

- States: IDLE, T0, T1, T2, DONE.
- Acceptance: an instruction is accepted on an edge where IDLE, `instr_valid` and `instr_ready` are all high. The word is latched and the FSM moves to T0.
- Strobe sequence per opcode (each step is exactly one cycle):
  - LDI (Ra <- C): T0 drives `imm_out` = C and `Rin[Ra]`.
  - MV (Ra <- Rb): T0 drives `Rout[Rb]` and `Rin[Ra]`.
  - ADDI (Ra <- Rb + C): T0 drives `Rout[Rb]`, `alu_imm` = C and `Zin`. T1 drives `Zout` and `Rin[Ra]`.
  - ADD (Ra <- Rb + Rc): T0 drives `Rout[Rb]` and `Yin`. T1 drives `Rout[Rc]` and `Zin`. T2 drives `Zout` and `Rin[Ra]`.
- After the last T-state the FSM enters DONE. DONE pulses `done` and returns to IDLE on the next edge.
- Illegal instruction (unknown opcode, or Ra/Rb/Rc >= `NREG` where that field is used): go T0 -> DONE with no strobes, and pulse `illegal` with `done`.
- Output decoding: outputs are decoded only from the state register and the latched instruction. There is no combinational path from `instr`/`instr_valid` to any output except `instr_ready`.
- At most one bit of `Rout` is high, and at most one bus driver (`Rout`, `Zout`, nonzero `imm_out`) is active per cycle.
- Sign extension: C[18] is replicated into bits [DATA_W-1:19].

## Timing

- Reset values: state IDLE; `instr_ready`=1; all strobes, `imm_out`, `alu_imm`, `done` and `illegal` are 0; the latched instruction is 0.
- Latency from the accept edge to the `done` cycle: LDI/MV 2 cycles; ADDI 3; ADD 4. An illegal instruction takes 2.
- `instr_ready` is low from T0 through DONE, so back-to-back throughput is one instruction per (latency + 1) cycles.
- `clear` mid-instruction: the next edge returns to IDLE, drops all strobes, discards the instruction, and produces no `done`.
- `clear` dominates `instr_valid` on the same edge; no accept occurs.

## Configuration

- `CTRL_SEQ_STEP_EN` defined: the `step` port exists. T0, T1 and T2 each hold, with their strobes held, until a cycle with `step`=1. The advance happens on that edge. IDLE and DONE are unaffected.
- `CTRL_SEQ_STEP_EN` undefined: there is no `step` port, and T-states advance every cycle.

## Structure

- Package `ctrl_pkg`:
  - Opcodes: OP_LDI=5'd1, OP_ADDI=5'd2, OP_ADD=5'd3, OP_MV=5'd4.
  - State enum.
  - Field bit-position constants.
- Sub-module `ctrl_decode` (combinational): latched instr -> opcode class, register indices, legality, sign-extended C.
- `ctrl_sequencer` holds the FSM, the instruction latch and the strobe generation.

## Test plan

- Reset, then LDI R1, 5 (C=5): T0 shows `Rin`=16'h0002 and `imm_out`=32'h5. `done` pulses at accept+2, and everything else is 0.
- ADDI R2, R1, 5: T0 shows `Rout`=16'h0002, `alu_imm`=5, `Zin`=1. T1 shows `Zout`=1, `Rin`=16'h0004. `done` at accept+3.
- ADD R3, R1, R2 then MV R4, R3 presented back-to-back: `instr_ready` is low for 4 cycles. Strobe order is Yin, Zin, Zout+Rin[3]. MV accepts on the first IDLE edge; T0 shows `Rout`=16'h0008, `Rin`=16'h0010.
- ADDI with C=19'h7FFFF: `alu_imm`=32'hFFFFFFFF. Opcode 5'd31: `illegal` and `done` at accept+2, with no strobes ever asserted.
- `clear` asserted during T1 of ADD: IDLE and all outputs 0 on the next edge, no `done`, and `instr_ready`=1.
- With `CTRL_SEQ_STEP_EN`, ADDI with `step` low for 3 cycles: T0 strobes are held for 3 cycles, and the FSM advances one state per `step` pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, instruction field positions and FSM types for ctrl_sequencer
package ctrl_pkg;

  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_MV   = 5'd4;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_W    = 19;

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_DONE} state_e;

  typedef enum logic [2:0] {CLS_LDI, CLS_MV, CLS_ADDI, CLS_ADD, CLS_ILL} op_class_e;

  function automatic logic reg_ok(input logic [3:0] idx, input int nreg);
    return int'(idx) < nreg;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational decode of the latched instruction word
// Yields the opcode class, register indices, legality and sign-extended immediate.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic [31:0]       i_instr,
  output op_class_e         o_class,
  output logic [3:0]        o_ra,
  output logic [3:0]        o_rb,
  output logic [3:0]        o_rc,
  output logic              o_legal,
  output logic [DATA_W-1:0] o_imm
);

  logic [4:0]     w_op;
  logic [C_W-1:0] w_c;
  logic           w_uses_rb;
  logic           w_uses_rc;

  always_comb begin
    w_op      = i_instr[OP_MSB:OP_LSB];
    w_c       = i_instr[C_MSB:0];
    o_ra      = i_instr[RA_MSB:RA_LSB];
    o_rb      = i_instr[RB_MSB:RB_LSB];
    o_rc      = i_instr[RC_MSB:RC_LSB];
    o_class   = CLS_ILL;
    w_uses_rb = 1'b0;
    w_uses_rc = 1'b0;
    case (w_op)
      OP_LDI:  o_class = CLS_LDI;
      OP_MV:   begin o_class = CLS_MV;   w_uses_rb = 1'b1; end
      OP_ADDI: begin o_class = CLS_ADDI; w_uses_rb = 1'b1; end
      OP_ADD:  begin o_class = CLS_ADD;  w_uses_rb = 1'b1; w_uses_rc = 1'b1; end
      default: o_class = CLS_ILL;
    endcase
    // Only fields the opcode actually reads can make it illegal.
    o_legal = (o_class != CLS_ILL) && reg_ok(o_ra, NREG)
              && (!w_uses_rb || reg_ok(o_rb, NREG))
              && (!w_uses_rc || reg_ok(o_rc, NREG));
    o_imm   = {{(DATA_W-C_W){w_c[C_W-1]}}, w_c};
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - T-state sequencer driving DataPath register-transfer strobes
// Optional CTRL_SEQ_STEP_EN adds a step input that gates every T-state advance.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
`ifdef CTRL_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              instr_ready,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic              Yin,
  output logic              Zin,
  output logic              Zout,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] alu_imm,
  output logic              done,
  output logic              illegal
);

  state_e            r_state;
  state_e            w_next_state;
  logic [31:0]       r_instr;
  logic              w_accept;
  logic              w_advance;
  op_class_e         w_class;
  logic [3:0]        w_ra;
  logic [3:0]        w_rb;
  logic [3:0]        w_rc;
  logic              w_legal;
  logic [DATA_W-1:0] w_imm;
  logic [NREG-1:0]   w_one;

  ctrl_decode #(.DATA_W(DATA_W), .NREG(NREG)) u_decode (
    .i_instr (r_instr),
    .o_class (w_class),
    .o_ra    (w_ra),
    .o_rb    (w_rb),
    .o_rc    (w_rc),
    .o_legal (w_legal),
    .o_imm   (w_imm)
  );

`ifdef CTRL_SEQ_STEP_EN
  assign w_advance = step;
`else
  assign w_advance = 1'b1;
`endif

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_ready && instr_valid;
  assign w_one       = {{(NREG-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) r_instr <= instr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_T0;
      S_T0: if (w_advance) begin
        if (!w_legal || w_class == CLS_LDI || w_class == CLS_MV) w_next_state = S_DONE;
        else                                                     w_next_state = S_T1;
      end
      S_T1:   if (w_advance) w_next_state = (w_class == CLS_ADD) ? S_T2 : S_DONE;
      S_T2:   if (w_advance) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes come only from r_state and r_instr, never from the live instr bus.
  always_comb begin
    Rin     = '0;
    Rout    = '0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zout    = 1'b0;
    imm_out = '0;
    alu_imm = '0;
    done    = 1'b0;
    illegal = 1'b0;
    case (r_state)
      S_T0: if (w_legal) begin
        case (w_class)
          CLS_LDI:  begin Rin = w_one << w_ra; imm_out = w_imm; end
          CLS_MV:   begin Rout = w_one << w_rb; Rin = w_one << w_ra; end
          CLS_ADDI: begin Rout = w_one << w_rb; alu_imm = w_imm; Zin = 1'b1; end
          CLS_ADD:  begin Rout = w_one << w_rb; Yin = 1'b1; end
          default:  ;
        endcase
      end
      S_T1: if (w_legal) begin
        if (w_class == CLS_ADD) begin
          Rout = w_one << w_rc;
          Zin  = 1'b1;
        end else begin
          Zout = 1'b1;
          Rin  = w_one << w_ra;
        end
      end
      S_T2: if (w_legal) begin
        Zout = 1'b1;
        Rin  = w_one << w_ra;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = !w_legal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer
// Expected per-cycle strobe sets are derived from the opcode rules, one entry per cycle after accept.
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] instr;
  logic        instr_valid;
`ifdef CTRL_SEQ_STEP_EN
  logic        step;
`endif
  logic        instr_ready;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        Yin;
  logic        Zin;
  logic        Zout;
  logic [31:0] imm_out;
  logic [31:0] alu_imm;
  logic        done;
  logic        illegal;

  ctrl_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .instr       (instr),
    .instr_valid (instr_valid),
`ifdef CTRL_SEQ_STEP_EN
    .step        (step),
`endif
    .instr_ready (instr_ready),
    .Rin         (Rin),
    .Rout        (Rout),
    .Yin         (Yin),
    .Zin         (Zin),
    .Zout        (Zout),
    .imm_out     (imm_out),
    .alu_imm     (alu_imm),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ready;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        yin;
    logic        zin;
    logic        zout;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        dn;
    logic        ill;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t idle_o;

  function automatic obs_t observe();
    obs_t o;
    o.ready = instr_ready;
    o.rin   = Rin;
    o.rout  = Rout;
    o.yin   = Yin;
    o.zin   = Zin;
    o.zout  = Zout;
    o.imm   = imm_out;
    o.alu   = alu_imm;
    o.dn    = done;
    o.ill   = illegal;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] sext19(input logic [18:0] c);
    int v;
    v = int'(c);
    if (v >= 262144) v = v - 524288;
    return 32'(v);
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  task automatic build(input logic [31:0] w);
    obs_t        e;
    logic [15:0] one;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [31:0] imm;
    one = 16'h1;
    op  = w[31:27];
    ra  = w[26:23];
    rb  = w[22:19];
    rc  = w[18:15];
    imm = sext19(w[18:0]);
    exp_q.delete();
    case (op)
      5'd1: begin e = '0; e.rin = one << ra; e.imm = imm; exp_q.push_back(e); end
      5'd4: begin e = '0; e.rout = one << rb; e.rin = one << ra; exp_q.push_back(e); end
      5'd2: begin
        e = '0; e.rout = one << rb; e.alu = imm; e.zin = 1'b1; exp_q.push_back(e);
        e = '0; e.zout = 1'b1; e.rin = one << ra; exp_q.push_back(e);
      end
      5'd3: begin
        e = '0; e.rout = one << rb; e.yin = 1'b1; exp_q.push_back(e);
        e = '0; e.rout = one << rc; e.zin = 1'b1; exp_q.push_back(e);
        e = '0; e.zout = 1'b1; e.rin = one << ra; exp_q.push_back(e);
      end
      default: begin e = '0; exp_q.push_back(e); end
    endcase
    e = '0;
    e.dn  = 1'b1;
    e.ill = !(op inside {5'd1, 5'd2, 5'd3, 5'd4});
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] w, input string tag);
    int n;
    @(negedge clock);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " idle"}, observe(), idle_o);
    instr       = w;
    instr_valid = 1'b1;
    build(w);
    @(posedge clock);
    foreach (exp_q[i]) begin
      @(negedge clock);
      instr       = $urandom;
      instr_valid = 1'($urandom_range(0, 1));
      chk($sformatf("%s cyc%0d", tag, i + 1), observe(), exp_q[i]);
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    idle_o       = '0;
    idle_o.ready = 1'b1;
`ifdef CTRL_SEQ_STEP_EN
    step = 1'b1;
`endif
    clear       = 1'b1;
    instr_valid = 1'b1;
    instr       = mk(5'd1, 4'd1, 4'd0, 19'd5);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset", observe(), idle_o);
    clear       = 1'b0;
    instr_valid = 1'b0;

    issue(mk(5'd1, 4'd1, 4'd0, 19'd5), "ldi_r1_5");
    issue(mk(5'd2, 4'd2, 4'd1, 19'd5), "addi_r2_r1_5");
    issue(mk(5'd3, 4'd3, 4'd1, {4'd2, 15'd0}), "add_r3_r1_r2");
    issue(mk(5'd4, 4'd4, 4'd3, 19'd0), "mv_r4_r3");
    issue(mk(5'd2, 4'd5, 4'd6, 19'h7FFFF), "addi_neg1");
    issue(mk(5'd31, 4'd1, 4'd2, 19'd3), "illegal_op31");
    issue(mk(5'd0, 4'd15, 4'd15, 19'h40000), "illegal_op0");

    // clear during T1 of an ADD discards it without a done pulse
    @(negedge clock);
    instr       = mk(5'd3, 4'd7, 4'd8, {4'd9, 15'd0});
    instr_valid = 1'b1;
    build(instr);
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("clr_add T0", observe(), exp_q[0]);
    @(negedge clock);
    chk("clr_add T1", observe(), exp_q[1]);
    clear = 1'b1;
    @(negedge clock);
    chk("clr_add flushed", observe(), idle_o);
    clear = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("clr_add no_done", observe(), idle_o);
    end

    // clear wins over a simultaneous instr_valid
    instr       = mk(5'd1, 4'd9, 4'd0, 19'd77);
    instr_valid = 1'b1;
    clear       = 1'b1;
    @(negedge clock);
    chk("clr_dom edge", observe(), idle_o);
    clear       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clock);
    chk("clr_dom no_accept", observe(), idle_o);

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 7));
      if (op == 5'd7) op = 5'($urandom_range(5, 31));
      issue({op, 27'($urandom)}, $sformatf("rand%0d_op%0d", k, op));
    end

`ifdef CTRL_SEQ_STEP_EN
    @(negedge clock);
    instr       = mk(5'd2, 4'd2, 4'd1, 19'd5);
    instr_valid = 1'b1;
    step        = 1'b0;
    build(instr);
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("step T0 hold%0d", s), observe(), exp_q[0]);
      if (s < 2) @(negedge clock);
    end
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    chk("step T1", observe(), exp_q[1]);
    @(negedge clock);
    chk("step T1 hold", observe(), exp_q[1]);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    chk("step done", observe(), exp_q[2]);
    @(negedge clock);
    chk("step idle", observe(), idle_o);
    step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
